id_ex_ctrl_pipe: RTL and testbench
==================================

Name: id_ex_ctrl_pipe

Overview:
- Registered successor to the combinational control decoder: decodes a 32-bit RV32I/RV64I-base instruction and writes the control word into an ID/EX pipeline register.
- Adds valid/ready handshake, load-use hazard detection with bubble insertion, and flush.
- Adds XLEN-parametrised byte enables, illegal-instruction flagging, and a saturating stall counter.
- Sits between the IF/ID register and the execute stage.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
BE_W, XLEN/8, byte-enable width.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds an instruction
id_ready  out  1  ID instruction accepted this cycle (combinational)
id_instr  in  32  instruction; opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20]
flush  in  1  kill the instruction in EX and the one in ID
ex_ready  in  1  execute stage can take a new EX word
ex_valid  out  1  EX register holds a valid instruction
ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump_return, ex_us, ex_illegal  out  1 each  registered controls
ex_alu_op  out  2  ALU operation class
ex_rw  out  2  writeback source select
ex_byte_en  out  BE_W  memory byte lanes
ex_rd  out  5  destination register
clr_count  in  1  synchronous clear of stall_count
stall_count  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset: every ex_* output and stall_count go to 0 asynchronously.
- Latency: decode is written into the EX register on the clk edge where id_valid and id_ready are both 1.
- Opcodes: r_type 0110011, load 0000011, store 0100011, branch 1100011, i_type 0010011, lui 0110111, auipc 0010111, jal 1101111, jalr 1100111.
- Any other opcode: ex_illegal=1, and reg_write, mem_read, mem_write, branch, jump_return are 0.
- alu_src = 1 for load, store, i_type, jalr.
- mem_to_reg = mem_read = 1 for load only.
- mem_write = 1 for store.
- branch = 1 for branch and jal.
- jump_return = 1 for jalr.
- reg_write = 1 for r_type, load, i_type, lui, auipc, jal, jalr.
- alu_op: 00 for load, store, auipc, jalr; 01 for branch; 10 for r_type, i_type; 11 for lui, jal.
- rw: 00 ALU/memory; 10 lui; 11 auipc; 01 jal, jalr.
- Memory ops (load or store) only; otherwise byte_en = 0 and us = 0:
  - funct3[1:0]: 00 -> 1 lane, 01 -> 2 lanes, 10 -> 4 lanes, 11 -> 8 lanes. Lanes are low-aligned, e.g. 0x01, 0x03, 0x0F, 0xFF.
  - us = funct3[2] for loads only.
- Illegal memory forms set ex_illegal=1 and clear mem_read, mem_write, reg_write:
  - funct3[1:0]=11 when XLEN=32;
  - load funct3 111, or 110 when XLEN=32;
  - store funct3[2]=1.
- Source use: rs1 is used by r_type, load, store, branch, i_type, jalr. rs2 is used by r_type, store, branch.
- hazard = ex_valid & ex_mem_read & (ex_rd != 0) & ((use_rs1 & ex_rd==rs1) | (use_rs2 & ex_rd==rs2)).
- advance = ~ex_valid | ex_ready.
- id_ready = advance & ~hazard & ~flush.
- Next-state priority, highest first:
  1. flush: ex_valid <= 0; nothing is accepted.
  2. ~advance: the EX register holds all fields unchanged.
  3. hazard with id_valid: bubble, ex_valid <= 0. The ID instruction is held upstream (id_ready=0). stall_count increments.
  4. id_valid: load the decoded word, ex_valid <= 1.
  5. Otherwise: ex_valid <= 0.
- When ex_valid=0, the control fields are don't-care, except reg_write, mem_write, mem_read, branch, which are forced to 0.
- stall_count: +1 per hazard bubble cycle; holds at all-ones; clr_count has priority over increment; not affected by flush.
- Reset asserted mid-stall clears everything. After release, the first accept needs id_valid=1 (no hazard is possible, since ex_valid=0).

Test Plan:
- After reset: instr 0x00A00093 (addi x1,x0,10), id_valid=1, ex_ready=1 -> next cycle ex_valid=1, reg_write=1, alu_src=1, alu_op=10, rw=00, byte_en=0, rd=1.
- lw x5,0(x2) then add x6,x5,x7 -> one bubble (ex_valid=0 with id_ready=0 for 1 cycle), stall_count=1, then add issues. Same pair with rd=x0 -> no stall.
- ex_ready=0 for 3 cycles while EX holds sw (funct3 010) -> EX fields stable, id_ready=0. byte_en=0x0F, mem_write=1 throughout.
- flush during a hazard -> ex_valid=0 next cycle, id_ready=0 that cycle, stall_count unchanged.
- XLEN=64, ld (funct3 011) -> byte_en=0xFF, us=0. XLEN=32, same instr -> ex_illegal=1, mem_read=0. Opcode 0x7F -> ex_illegal=1.
- CNT_W=2: 5 consecutive hazard bubbles -> stall_count saturates at 3. clr_count -> 0.

Source files
------------

// File: rtl/id_ex_ctrl_pipe_if.sv
// ID -> EX control handshake bundle.
// master drives ID side and EX ready; slave is the pipe register.
interface id_ex_ctrl_pipe_if #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN/8
);
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic            ex_ready;
  logic            ex_valid;
  logic            ex_alu_src;
  logic            ex_mem_to_reg;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_jump_return;
  logic            ex_us;
  logic            ex_illegal;
  logic [1:0]      ex_alu_op;
  logic [1:0]      ex_rw;
  logic [BE_W-1:0] ex_byte_en;
  logic [4:0]      ex_rd;

  modport master (
    output id_valid, id_instr, ex_ready,
    input  id_ready, ex_valid,
    input  ex_alu_src, ex_mem_to_reg,
    input  ex_reg_write, ex_mem_read,
    input  ex_mem_write, ex_branch,
    input  ex_jump_return, ex_us,
    input  ex_illegal, ex_alu_op, ex_rw,
    input  ex_byte_en, ex_rd
  );

  modport slave (
    input  id_valid, id_instr, ex_ready,
    output id_ready, ex_valid,
    output ex_alu_src, ex_mem_to_reg,
    output ex_reg_write, ex_mem_read,
    output ex_mem_write, ex_branch,
    output ex_jump_return, ex_us,
    output ex_illegal, ex_alu_op, ex_rw,
    output ex_byte_en, ex_rd
  );
endinterface

// File: rtl/id_ex_ctrl_pipe.sv
// ID decode into a registered EX control word with handshake,
// load-use bubbles, flush and a saturating stall counter.
module id_ex_ctrl_pipe #(
  parameter int XLEN  = 32,
  parameter int BE_W  = XLEN/8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_ctrl_pipe_if.slave bus,
  input  logic             flush,
  input  logic             clr_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic            alu_src;
    logic            mem_to_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump_return;
    logic            us;
    logic            illegal;
    logic [1:0]      alu_op;
    logic [1:0]      rw;
    logic [BE_W-1:0] byte_en;
    logic [4:0]      rd;
  } ctrl_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       unused_hi;

  assign opc       = bus.id_instr[6:0];
  assign f3        = bus.id_instr[14:12];
  assign rs1       = bus.id_instr[19:15];
  assign rs2       = bus.id_instr[24:20];
  assign unused_hi = ^bus.id_instr[31:25];

  logic is_r, is_ld, is_st, is_br, is_i;
  logic is_lui, is_aui, is_jal, is_jalr;

  assign is_r    = opc == 7'b0110011;
  assign is_ld   = opc == 7'b0000011;
  assign is_st   = opc == 7'b0100011;
  assign is_br   = opc == 7'b1100011;
  assign is_i    = opc == 7'b0010011;
  assign is_lui  = opc == 7'b0110111;
  assign is_aui  = opc == 7'b0010111;
  assign is_jal  = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;

  logic use_rs1, use_rs2;

  assign use_rs1 = is_r | is_ld | is_st
                 | is_br | is_i | is_jalr;
  assign use_rs2 = is_r | is_st | is_br;

  logic       rv32;
  logic       mem_bad;
  logic [7:0] lanes8;

  assign rv32 = XLEN == 32;

  // Size field to low-aligned lane mask, cut to the bus width.
  always_comb begin
    lanes8 = 8'h00;
    unique case (f3[1:0])
      2'b00:   lanes8 = 8'h01;
      2'b01:   lanes8 = 8'h03;
      2'b10:   lanes8 = 8'h0f;
      default: lanes8 = 8'hff;
    endcase
  end

  // 64-bit accesses on RV32, ld-unsigned forms, signed-less stores.
  assign mem_bad = (is_ld | is_st)
                 & ((rv32 & (f3[1:0] == 2'b11))
                 | (is_ld & (f3 == 3'b111))
                 | (is_ld & rv32 & (f3 == 3'b110))
                 | (is_st & f3[2]));

  ctrl_t dec;

  // Combinational decode of the ID instruction.
  always_comb begin
    dec    = '0;
    dec.rd = bus.id_instr[11:7];
    unique case (1'b1)
      is_r: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      is_ld: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_read   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.byte_en    = lanes8[BE_W-1:0];
        dec.us         = f3[2];
      end
      is_st: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.byte_en   = lanes8[BE_W-1:0];
      end
      is_br: begin
        dec.branch = 1'b1;
        dec.alu_op = 2'b01;
      end
      is_i: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      is_lui: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b11;
        dec.rw        = 2'b10;
      end
      is_aui: begin
        dec.reg_write = 1'b1;
        dec.rw        = 2'b11;
      end
      is_jal: begin
        dec.branch    = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b11;
        dec.rw        = 2'b01;
      end
      is_jalr: begin
        dec.alu_src     = 1'b1;
        dec.jump_return = 1'b1;
        dec.reg_write   = 1'b1;
        dec.rw          = 2'b01;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (mem_bad) begin
      dec.illegal   = 1'b1;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.reg_write = 1'b0;
    end
  end

  ctrl_t ex_q;
  logic  ex_v;
  logic  hazard;
  logic  advance;
  logic  accept;
  logic  bubble;

  assign hazard  = ex_v & ex_q.mem_read
                 & (ex_q.rd != 5'd0)
                 & ((use_rs1 & (ex_q.rd == rs1))
                 | (use_rs2 & (ex_q.rd == rs2)));
  assign advance = ~ex_v | bus.ex_ready;
  assign bus.id_ready = advance & ~hazard & ~flush;
  assign accept  = bus.id_ready & bus.id_valid;
  assign bubble  = advance & hazard
                 & bus.id_valid & ~flush;

  // EX register: load on accept, kill on flush or
  // when it drains with nothing new, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v <= 1'b0;
      ex_q <= '0;
    end else if (accept) begin
      ex_v <= 1'b1;
      ex_q <= dec;
    end else if (flush | advance) begin
      ex_v           <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
      ex_q.mem_write <= 1'b0;
      ex_q.branch    <= 1'b0;
    end
  end

  // Bubble counter, sticks at all-ones until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (clr_count) begin
      stall_count <= '0;
    end else if (bubble && stall_count != '1) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign bus.ex_valid       = ex_v;
  assign bus.ex_alu_src     = ex_q.alu_src;
  assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_branch      = ex_q.branch;
  assign bus.ex_jump_return = ex_q.jump_return;
  assign bus.ex_us          = ex_q.us;
  assign bus.ex_illegal     = ex_q.illegal;
  assign bus.ex_alu_op      = ex_q.alu_op;
  assign bus.ex_rw          = ex_q.rw;
  assign bus.ex_byte_en     = ex_q.byte_en;
  assign bus.ex_rd          = ex_q.rd;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: RV32 and RV64 copies on shared
// stimulus, each checked against its own behavioural model.
module tb_id_ex_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = 32'h0;
  logic        ex_ready = 1'b1;
  logic        flush = 1'b0;
  logic        clr_count = 1'b0;
  logic [15:0] sc32;
  logic [1:0]  sc64;

  always #5 clk = ~clk;

  id_ex_ctrl_pipe_if #(.XLEN(32)) b32 ();
  id_ex_ctrl_pipe_if #(.XLEN(64)) b64 ();

  assign b32.id_valid = id_valid;
  assign b32.id_instr = id_instr;
  assign b32.ex_ready = ex_ready;
  assign b64.id_valid = id_valid;
  assign b64.id_instr = id_instr;
  assign b64.ex_ready = ex_ready;

  id_ex_ctrl_pipe #(.XLEN(32), .CNT_W(16)) d32 (
    .clk(clk), .rst_n(rst_n), .bus(b32),
    .flush(flush), .clr_count(clr_count),
    .stall_count(sc32)
  );

  id_ex_ctrl_pipe #(.XLEN(64), .CNT_W(2)) d64 (
    .clk(clk), .rst_n(rst_n), .bus(b64),
    .flush(flush), .clr_count(clr_count),
    .stall_count(sc64)
  );

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump_return;
    logic       us;
    logic       illegal;
    logic [1:0] alu_op;
    logic [1:0] rw;
    logic [7:0] byte_en;
    logic [4:0] rd;
  } word_t;

  localparam int K_R = 0, K_LD = 1, K_ST = 2;
  localparam int K_BR = 3, K_I = 4, K_LUI = 5;
  localparam int K_AUI = 6, K_JAL = 7, K_JALR = 8;
  localparam int K_BAD = 9;

  int n_cmp = 0;
  int n_bad = 0;

  word_t st [2];
  int    cnt [2];
  int    xl [2]   = '{32, 64};
  int    cmax [2] = '{65535, 3};

  function automatic int kind(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b0010011: return K_I;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUI;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic word_t model_decode(
    input logic [31:0] ins, input int xlen);
    word_t w;
    int k, n;
    logic [2:0] f3;
    bit mem, bad;
    w = '0;
    k = kind(ins[6:0]);
    f3 = ins[14:12];
    w.valid = 1'b1;
    w.rd = ins[11:7];
    w.alu_src = k inside {K_LD, K_ST, K_I, K_JALR};
    w.mem_to_reg = (k == K_LD);
    w.mem_read = (k == K_LD);
    w.mem_write = (k == K_ST);
    w.branch = k inside {K_BR, K_JAL};
    w.jump_return = (k == K_JALR);
    w.reg_write = k inside {K_R, K_LD, K_I, K_LUI,
                            K_AUI, K_JAL, K_JALR};
    case (k)
      K_BR:         w.alu_op = 2'd1;
      K_R, K_I:     w.alu_op = 2'd2;
      K_LUI, K_JAL: w.alu_op = 2'd3;
      default:      w.alu_op = 2'd0;
    endcase
    case (k)
      K_LUI:         w.rw = 2'd2;
      K_AUI:         w.rw = 2'd3;
      K_JAL, K_JALR: w.rw = 2'd1;
      default:       w.rw = 2'd0;
    endcase
    mem = (k == K_LD) || (k == K_ST);
    if (mem) begin
      n = 1 << f3[1:0];
      w.byte_en = 8'(((1 << n) - 1)
                  & ((1 << (xlen / 8)) - 1));
      w.us = (k == K_LD) && f3[2];
    end
    bad = mem && ((xlen == 32 && f3[1:0] == 2'd3)
        || (k == K_LD && (f3 == 3'd7
            || (f3 == 3'd6 && xlen == 32)))
        || (k == K_ST && f3[2]));
    w.illegal = (k == K_BAD) || bad;
    if (bad) begin
      w.mem_read = 1'b0;
      w.mem_write = 1'b0;
      w.reg_write = 1'b0;
    end
    return w;
  endfunction

  task automatic chk(input string nm, input int d,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h",
               nm, xl[d], act, exp);
    end
  endtask

  task automatic lit(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] vis(input word_t w);
    return {w.valid, w.reg_write, w.mem_read,
            w.mem_write, w.branch};
  endfunction

  // Compare both DUTs to the model, then advance the model
  // with the inputs that the next rising edge will see.
  always @(negedge clk) begin
    word_t got [2];
    logic [63:0] sc [2];
    got[0] = '{b32.ex_valid, b32.ex_alu_src,
      b32.ex_mem_to_reg, b32.ex_reg_write,
      b32.ex_mem_read, b32.ex_mem_write, b32.ex_branch,
      b32.ex_jump_return, b32.ex_us, b32.ex_illegal,
      b32.ex_alu_op, b32.ex_rw,
      {4'h0, b32.ex_byte_en}, b32.ex_rd};
    got[1] = '{b64.ex_valid, b64.ex_alu_src,
      b64.ex_mem_to_reg, b64.ex_reg_write,
      b64.ex_mem_read, b64.ex_mem_write, b64.ex_branch,
      b64.ex_jump_return, b64.ex_us, b64.ex_illegal,
      b64.ex_alu_op, b64.ex_rw,
      b64.ex_byte_en, b64.ex_rd};
    sc[0] = 64'(sc32);
    sc[1] = 64'(sc64);
    for (int d = 0; d < 2; d++) begin
      logic rdy_got;
      bit hz, adv, rdy, u1, u2;
      int k;
      rdy_got = (d == 0) ? b32.id_ready : b64.id_ready;
      if (!rst_n) begin
        st[d] = '0;
        cnt[d] = 0;
        chk("reset_word", d, 64'(got[d]), 64'(0));
        chk("reset_count", d, sc[d], 64'(0));
      end else begin
        if (st[d].valid)
          chk("ex_word", d, 64'(got[d]), 64'(st[d]));
        else
          chk("ex_idle", d, 64'(vis(got[d])),
              64'(vis(st[d])));
        chk("stall_count", d, sc[d], 64'(cnt[d]));
        k = kind(id_instr[6:0]);
        u1 = k inside {K_R, K_LD, K_ST, K_BR, K_I, K_JALR};
        u2 = k inside {K_R, K_ST, K_BR};
        hz = st[d].valid && st[d].mem_read
          && st[d].rd != 0
          && ((u1 && st[d].rd == id_instr[19:15])
          || (u2 && st[d].rd == id_instr[24:20]));
        adv = !st[d].valid || ex_ready;
        rdy = adv && !hz && !flush;
        chk("id_ready", d, 64'(rdy_got), 64'(rdy));
        if (flush || (adv && !(id_valid && rdy))) begin
          if (!flush && adv && hz && id_valid
              && cnt[d] < cmax[d])
            cnt[d]++;
          st[d].valid = 1'b0;
          st[d].reg_write = 1'b0;
          st[d].mem_read = 1'b0;
          st[d].mem_write = 1'b0;
          st[d].branch = 1'b0;
        end else if (adv) begin
          st[d] = model_decode(id_instr, xl[d]);
        end
        if (clr_count) cnt[d] = 0;
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic er, input logic fl,
                       input logic clr);
    @(posedge clk);
    #1;
    id_valid = v;
    id_instr = ins;
    ex_ready = er;
    flush = fl;
    clr_count = clr;
  endtask

  localparam logic [31:0] ADDI = 32'h00A00093;
  localparam logic [31:0] LW   = 32'h00012283;
  localparam logic [31:0] ADD  = 32'h00728333;
  localparam logic [31:0] LW0  = 32'h00012003;
  localparam logic [31:0] ADD0 = 32'h00700333;
  localparam logic [31:0] SW   = 32'h00312023;
  localparam logic [31:0] LD   = 32'h00013283;
  localparam logic [31:0] ILL  = 32'h0000007F;

  logic [6:0] ops [10] = '{7'h33, 7'h03, 7'h23, 7'h63,
    7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    drive(1, ADDI, 1, 0, 0);
    drive(0, ADDI, 1, 0, 0);
    @(negedge clk);
    lit("addi_valid", b32.ex_valid, 1);
    lit("addi_rw_en", b32.ex_reg_write, 1);
    lit("addi_src", b32.ex_alu_src, 1);
    lit("addi_aluop", b32.ex_alu_op, 2);
    lit("addi_rw", b32.ex_rw, 0);
    lit("addi_be", b32.ex_byte_en, 0);
    lit("addi_rd", b32.ex_rd, 1);

    drive(1, LW, 1, 0, 0);
    drive(1, ADD, 1, 0, 0);
    @(negedge clk);
    lit("lu_hold_ready", b32.id_ready, 0);
    lit("lu_lw_rd", b32.ex_rd, 5);
    drive(1, ADD, 1, 0, 0);
    @(negedge clk);
    lit("lu_bubble", b32.ex_valid, 0);
    lit("lu_count", sc32, 1);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    lit("lu_add_rd", b32.ex_rd, 6);
    lit("lu_add_valid", b32.ex_valid, 1);

    drive(1, LW0, 1, 0, 0);
    drive(1, ADD0, 1, 0, 0);
    @(negedge clk);
    lit("x0_ready", b32.id_ready, 1);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    lit("x0_add_rd", b32.ex_rd, 6);
    lit("x0_count", sc32, 1);

    drive(1, SW, 1, 0, 0);
    drive(1, ADDI, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      lit("sw_valid", b32.ex_valid, 1);
      lit("sw_mw", b32.ex_mem_write, 1);
      lit("sw_be", b32.ex_byte_en, 4'hF);
      lit("sw_ready", b32.id_ready, 0);
      drive(1, ADDI, 0, 0, 0);
    end
    drive(0, 0, 1, 0, 0);

    drive(1, LW, 1, 0, 0);
    drive(1, ADD, 1, 1, 0);
    @(negedge clk);
    lit("fl_ready", b32.id_ready, 0);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    lit("fl_valid", b32.ex_valid, 0);
    lit("fl_count", sc32, 1);

    drive(1, LD, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    lit("ld64_be", b64.ex_byte_en, 8'hFF);
    lit("ld64_us", b64.ex_us, 0);
    lit("ld64_ill", b64.ex_illegal, 0);
    lit("ld32_ill", b32.ex_illegal, 1);
    lit("ld32_mr", b32.ex_mem_read, 0);
    drive(1, ILL, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    lit("op7f_ill32", b32.ex_illegal, 1);
    lit("op7f_ill64", b64.ex_illegal, 1);
    lit("op7f_rw", b64.ex_reg_write, 0);

    repeat (5) begin
      drive(1, LW, 1, 0, 0);
      drive(1, ADD, 1, 0, 0);
      drive(1, ADD, 1, 0, 0);
    end
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    lit("sat_count64", sc64, 3);
    lit("sat_count32", sc32, 6);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    lit("clr_count64", sc64, 0);
    lit("clr_count32", sc32, 0);

    drive(1, LW, 1, 0, 0);
    drive(1, ADD, 1, 0, 0);
    #3 rst_n = 1'b0;
    @(negedge clk);
    lit("rst_valid", b32.ex_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    lit("rst_ready", b32.id_ready, 1);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    lit("rst_add_rd", b32.ex_rd, 6);

    for (int i = 0; i < 3000; i++) begin
      logic [6:0] op;
      logic [31:0] ins;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) op = 7'($urandom);
      ins = {7'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 3'($urandom),
             5'($urandom_range(0, 3)), op};
      drive($urandom_range(0, 3) != 0, ins,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0);
      rst_n = !($urandom_range(0, 399) == 0);
    end
    drive(0, 0, 1, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
